// File: rtl/intc_pkg.sv
// Shared types for the vectored interrupt controller: FSM state encoding
// and the configuration-register select encodings.
package intc_pkg;

  // Controller phase: nothing posted, posted to the CPU, handler running.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intc_state_e;

  // cfg_sel values for configuration writes.
  localparam logic CFG_MASK = 1'b0;
  localparam logic CFG_TRIG = 1'b1;

endpackage : intc_pkg

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder: valid_o when any request bit is set,
// id_o is the index of the lowest set bit (0 when nothing is set).
module intc_prio_enc #(
  parameter  int unsigned N    = 8,
  localparam int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o = ID_W'(i);
      end
    end
  end

endmodule : intc_prio_enc

// File: rtl/interrupt_controller.sv
// Vectored interrupt controller: NUM_IRQ request channels with per-channel
// mask, pending latches, fixed lowest-index-first priority and a
// request / acknowledge / end-of-interrupt handshake to the CPU.
//
// Optional feature: define INTC_LEVEL_EN to add the trigger-mode register
// (cfg_sel = CFG_TRIG) that makes selected channels level-sensitive.
// Without it every channel is edge-triggered and CFG_TRIG writes are ignored.
//
// CPU handshake: irq_req is asserted from the cycle after arbitration and
// stays high, with irq_id / irq_vector stable, until the CPU pulses irq_ack.
// The cycle after irq_ack, irq_req drops and in_service rises; in_service
// stays high until the CPU pulses irq_eoi, after which the controller is idle
// again the next cycle. irq_ack outside REQ and irq_eoi outside SERVICE are
// ignored. Only one interrupt is in flight at a time (no nesting).
module interrupt_controller
  import intc_pkg::*;
#(
  parameter  int unsigned NUM_IRQ    = 8,
  parameter  int unsigned ADDR_W     = 8,
  parameter  int unsigned VEC_BASE   = 'h80,
  parameter  int unsigned VEC_STRIDE = 4,
  localparam int unsigned ID_W       = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cfg_we,
  input  logic               cfg_sel,
  input  logic [NUM_IRQ-1:0] cfg_wdata,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [ADDR_W-1:0]  irq_vector,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_service,
  output intc_state_e        dbg_state
);

  // Handler address of a channel, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] vec_of(input logic [ID_W-1:0] id);
    return ADDR_W'(VEC_BASE) + (ADDR_W'(id) * ADDR_W'(VEC_STRIDE));
  endfunction

  intc_state_e        state_q;
  logic               irq_req_q;
  logic               in_service_q;
  logic [ID_W-1:0]    irq_id_q;
  logic [ADDR_W-1:0]  irq_vector_q;

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] trig_mode;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;

  logic [NUM_IRQ-1:0] edge_set;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] arb_req;
  logic               arb_valid;
  logic [ID_W-1:0]    arb_id;

  // Previous-cycle copy of the request lines for edge detection; loading it
  // during reset means a line held high through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= irq_in;
    end else begin
      irq_q <= irq_in;
    end
  end

  // Mask register: 1 enables the channel for arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '1;
    end else if (cfg_we && (cfg_sel == CFG_MASK)) begin
      mask_q <= cfg_wdata;
    end
  end

`ifdef INTC_LEVEL_EN
  logic [NUM_IRQ-1:0] trig_q;

  // Trigger-mode register: 1 makes the channel level-sensitive.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q <= '0;
    end else if (cfg_we && (cfg_sel == CFG_TRIG)) begin
      trig_q <= cfg_wdata;
    end
  end

  assign trig_mode = trig_q;
`else
  assign trig_mode = '0;
`endif

  // Next pending value: edge channels set on a rising edge and clear when
  // acknowledged (a same-cycle new edge wins so the interrupt re-posts);
  // level channels simply follow the request line.
  always_comb begin
    edge_set  = irq_in & ~irq_q;
    ack_clr   = '0;
    if ((state_q == REQ) && irq_ack) begin
      ack_clr = NUM_IRQ'(1) << irq_id_q;
    end
    pending_d = (((pending_q & ~ack_clr) | edge_set) & ~trig_mode)
              | (irq_in & trig_mode);
  end

  // Pending latches; everything outstanding is lost on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign arb_req = pending_q & mask_q;

  intc_prio_enc #(
    .N (NUM_IRQ)
  ) u_prio_enc (
    .req_i   (arb_req),
    .valid_o (arb_valid),
    .id_o    (arb_id)
  );

  // Control FSM with registered CPU-facing outputs. Arbitration only happens
  // in IDLE, so the posted id/vector cannot change until the next posting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_req_q    <= 1'b0;
      in_service_q <= 1'b0;
      irq_id_q     <= '0;
      irq_vector_q <= ADDR_W'(VEC_BASE);
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            state_q      <= REQ;
            irq_req_q    <= 1'b1;
            irq_id_q     <= arb_id;
            irq_vector_q <= vec_of(arb_id);
          end
        end
        REQ: begin
          if (irq_ack) begin
            state_q      <= SERVICE;
            irq_req_q    <= 1'b0;
            in_service_q <= 1'b1;
          end
        end
        SERVICE: begin
          if (irq_eoi) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          irq_req_q    <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req    = irq_req_q;
  assign in_service = in_service_q;
  assign irq_id     = irq_id_q;
  assign irq_vector = irq_vector_q;
  assign pending    = pending_q;
  assign dbg_state  = state_q;

endmodule : interrupt_controller

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller (default parameters).
// Directed scenarios followed by a randomized run, every cycle compared
// against a rule-level reference model.
module tb_interrupt_controller;
  import intc_pkg::*;

  localparam int N          = 8;
  localparam int VEC_BASE   = 'h80;
  localparam int VEC_STRIDE = 4;
`ifdef INTC_LEVEL_EN
  localparam bit LEVEL = 1'b1;
`else
  localparam bit LEVEL = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_in;
  logic         cfg_we;
  logic         cfg_sel;
  logic [N-1:0] cfg_wdata;
  logic         irq_ack;
  logic         irq_eoi;
  logic         irq_req;
  logic [2:0]   irq_id;
  logic [7:0]   irq_vector;
  logic [N-1:0] pending;
  logic         in_service;
  intc_state_e  dbg_state;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_wdata  (cfg_wdata),
    .irq_ack    (irq_ack),
    .irq_eoi    (irq_eoi),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_vector (irq_vector),
    .pending    (pending),
    .in_service (in_service),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = nothing posted, 1 = posted (awaiting ack), 2 = handler running
  int           m_phase;
  int           m_id;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_mask;
  logic [N-1:0] m_trig;
  logic [N-1:0] m_prev;

  task automatic model_step();
    logic [N-1:0] np;
    int           win;
    if (reset) begin
      m_phase = 0;
      m_id    = 0;
      m_pend  = '0;
      m_mask  = '1;
      m_trig  = '0;
      m_prev  = irq_in;
    end else begin
      np = m_pend;
      for (int i = 0; i < N; i++) begin
        if (m_trig[i]) begin
          np[i] = irq_in[i];
        end else begin
          if (m_phase == 1 && irq_ack && m_id == i) np[i] = 1'b0;
          if (irq_in[i] && !m_prev[i]) np[i] = 1'b1;
        end
      end
      case (m_phase)
        0: begin
          win = -1;
          for (int i = N - 1; i >= 0; i--) begin
            if (m_pend[i] && m_mask[i]) win = i;
          end
          if (win >= 0) begin
            m_phase = 1;
            m_id    = win;
          end
        end
        1: if (irq_ack) m_phase = 2;
        default: if (irq_eoi) m_phase = 0;
      endcase
      if (cfg_we) begin
        if (!cfg_sel) m_mask = cfg_wdata;
        else if (LEVEL) m_trig = cfg_wdata;
      end
      m_pend = np;
      m_prev = irq_in;
    end
  endtask

  // One clock: advance model with the inputs sampled at this edge, then
  // compare all CPU-visible outputs shortly after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("irq_req",    irq_req,    (m_phase == 1));
    chk("in_service", in_service, (m_phase == 2));
    chk("irq_id",     irq_id,     m_id);
    chk("irq_vector", irq_vector, (VEC_BASE + m_id * VEC_STRIDE) % 256);
    chk("pending",    pending,    m_pend);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_ack();
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    irq_eoi = 1'b1;
    cycle();
    irq_eoi = 1'b0;
  endtask

  task automatic cfg_write(input logic sel, input logic [N-1:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_wdata = data;
    cycle();
    cfg_we    = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    irq_in    = 8'h01;
    cfg_we    = 1'b0;
    cfg_sel   = 1'b0;
    cfg_wdata = '0;
    irq_ack   = 1'b0;
    irq_eoi   = 1'b0;
    #1;

    // 1) ch0 held high through reset: no spurious edge
    cycles(2);
    chk("rst_req",    irq_req, 0);
    chk("rst_vector", irq_vector, 8'h80);
    chk("rst_pend",   pending, 0);
    reset = 1'b0;
    cycles(3);
    chk("t1_no_spurious", irq_req, 0);
    irq_in = 8'h00;
    cycle();
    irq_in = 8'h01;
    cycle();
    chk("t1_pend_n1", pending, 8'h01);
    chk("t1_req_n1",  irq_req, 0);
    cycle();
    chk("t1_req_n2", irq_req, 1);
    chk("t1_id",     irq_id, 0);
    chk("t1_vec",    irq_vector, 8'h80);
    do_ack();
    chk("t1_ack_req", irq_req, 0);
    chk("t1_ack_svc", in_service, 1);
    do_eoi();
    chk("t1_eoi_svc", in_service, 0);

    // 2) simultaneous edges on ch5 and ch2: lowest index first
    irq_in = 8'h00;
    cycle();
    irq_in = 8'h24;
    cycles(2);
    chk("t2_id_a",  irq_id, 2);
    chk("t2_vec_a", irq_vector, 8'h88);
    do_ack();
    do_eoi();
    cycle();
    chk("t2_req_b", irq_req, 1);
    chk("t2_id_b",  irq_id, 5);
    chk("t2_vec_b", irq_vector, 8'h94);
    do_ack();
    do_eoi();
    irq_in = 8'h00;
    cycle();

    // 3) masked channel still latches pending; unmask posts it
    cfg_write(CFG_MASK, 8'hFB);
    irq_in = 8'h04;
    cycle();
    irq_in = 8'h00;
    cycles(2);
    chk("t3_pend",   pending, 8'h04);
    chk("t3_no_req", irq_req, 0);
    cfg_write(CFG_MASK, 8'hFF);
    chk("t3_req_c1", irq_req, 0);
    cycle();
    chk("t3_req_c2", irq_req, 1);
    chk("t3_id",     irq_id, 2);
    do_ack();
    do_eoi();

    // 4) new edge on ch3 in the same cycle as its ack: set wins
    irq_in = 8'h08;
    cycle();
    irq_in = 8'h00;
    cycle();
    chk("t4_id", irq_id, 3);
    irq_in  = 8'h08;
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    irq_in  = 8'h00;
    chk("t4_pend_kept", pending[3], 1);
    chk("t4_svc",       in_service, 1);
    do_eoi();
    cycle();
    chk("t4_repost", irq_req, 1);
    chk("t4_id_b",   irq_id, 3);
    do_ack();
    do_eoi();

    // 5) reset while in SERVICE with work pending
    irq_in = 8'h01;
    cycles(2);
    do_ack();
    irq_in = 8'h31;
    cycle();
    chk("t5_pend", pending, 8'h30);
    chk("t5_svc",  in_service, 1);
    reset = 1'b1;
    cycle();
    chk("t5_rst_req",  irq_req, 0);
    chk("t5_rst_svc",  in_service, 0);
    chk("t5_rst_pend", pending, 0);
    reset  = 1'b0;
    irq_in = 8'h00;
    cycles(2);

    // 6) level-sensitive channel re-posts while line stays high
`ifdef INTC_LEVEL_EN
    cfg_write(CFG_TRIG, 8'h02);
    irq_in = 8'h02;
    cycles(2);
    chk("t6_id", irq_id, 1);
    do_ack();
    chk("t6_pend_ack", pending[1], 1);
    do_eoi();
    cycle();
    chk("t6_repost", irq_req, 1);
    chk("t6_id_b",   irq_id, 1);
    irq_in = 8'h00;
    do_ack();
    do_eoi();
    cfg_write(CFG_TRIG, 8'h00);
`else
    // Trigger-mode writes are ignored: a held line posts only once.
    cfg_write(CFG_TRIG, 8'hFF);
    irq_in = 8'h02;
    cycles(2);
    do_ack();
    chk("t6_edge_clr", pending[1], 0);
    do_eoi();
    cycle();
    chk("t6_no_repost", irq_req, 0);
    irq_in = 8'h00;
    cycle();
`endif

    // 7) randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      reset   = ($urandom_range(0, 299) == 0);
      irq_in  = ($urandom_range(0, 1) == 0) ? irq_in : N'($urandom);
      irq_ack = ($urandom_range(0, 3) == 0);
      irq_eoi = ($urandom_range(0, 3) == 0);
      cfg_we  = ($urandom_range(0, 19) == 0);
      cfg_sel = 1'($urandom_range(0, 1));
      cfg_wdata = N'($urandom);
      cycle();
    end
    reset   = 1'b0;
    irq_ack = 1'b0;
    irq_eoi = 1'b0;
    cfg_we  = 1'b0;
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_interrupt_controller
